// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter stage: source select
// encoding, the hard-wired zero register and the select-width helper.
package wb_pkg;

  typedef enum logic [1:0] {
    SRC_MEM = 2'd0,
    SRC_ALU = 2'd1,
    SRC_PC4 = 2'd2,
    SRC_IMM = 2'd3
  } wb_src_e;

  localparam int WB_ZERO_REG = 0;

  // Width of the pipeline source select; a single source still gets one bit.
  function automatic int wb_selw(input int nsrc);
    return (nsrc > 1) ? $clog2(nsrc) : 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter.sv
// Ready/grant logic for the single register-file write port. The in-order
// pipeline normally wins; a long-unit result that keeps losing accumulates a
// starvation count and takes priority once it reaches STARVE_LIMIT.
// lu_ready never depends on lu_valid, only on the pipeline request and the
// registered starvation count.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_reg_write,
  input  logic flush,
  input  logic lu_valid,
  output logic in_ready,
  output logic lu_ready,
  output logic grant_p,
  output logic grant_l
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CW-1:0] starve_cnt;
  logic          lu_prio;
  logic          pipe_claim;
  logic          lu_stall;

  // A flushed or non-writing pipeline transaction never claims the port.
  assign pipe_claim = in_valid & in_reg_write & ~flush;
  assign lu_prio    = (starve_cnt == CW'(STARVE_LIMIT));
  assign in_ready   = ~(lu_valid & lu_prio);
  assign lu_ready   = lu_prio | ~pipe_claim;
  assign grant_l    = lu_valid & lu_ready;
  assign grant_p    = in_valid & in_ready & ~grant_l;
  assign lu_stall   = lu_valid & ~lu_ready;

  // Count consecutive lost cycles of a pending long-unit result, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (lu_stall) begin
      starve_cnt <= lu_prio ? starve_cnt : starve_cnt + CW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/wb_arbiter_stage.sv
// Registered write-back stage: selects the pipeline write data from NSRC
// packed sources, arbitrates the register-file write port against an
// out-of-band long-latency unit and registers the winning write.
// Writes to register 0 complete their handshake but issue no write.
// Optional build macro WB_ARB_STATS_EN adds 32-bit activity counters.
module wb_arbiter_stage
  import wb_pkg::*;
#(
  parameter  int N            = 32,
  parameter  int NSRC         = 4,
  parameter  int RW           = 5,
  parameter  int STARVE_LIMIT = 4,
  localparam int SELW         = wb_selw(NSRC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [RW-1:0]     in_rd,
  input  logic [SELW-1:0]   in_sel,
  input  logic [NSRC*N-1:0] in_src,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [RW-1:0]     lu_rd,
  input  logic [N-1:0]      lu_data,
  output logic              rf_we,
  output logic [RW-1:0]     rf_waddr,
  output logic [N-1:0]      rf_wdata
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]       stat_pipe_wr,
  output logic [31:0]       stat_lu_wr,
  output logic [31:0]       stat_lu_stall
`endif
);

  logic         grant_p;
  logic         grant_l;
  logic         req_p;
  logic         req_l;
  logic         write_p;
  logic         write_l;
  logic [N-1:0] pipe_data;

  wb_port_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_reg_write(in_reg_write),
    .flush       (flush),
    .lu_valid    (lu_valid),
    .in_ready    (in_ready),
    .lu_ready    (lu_ready),
    .grant_p     (grant_p),
    .grant_l     (grant_l)
  );

  assign req_p   = in_valid & in_reg_write & ~flush & (in_rd != RW'(WB_ZERO_REG));
  assign req_l   = lu_valid & (lu_rd != RW'(WB_ZERO_REG));
  assign write_p = grant_p & req_p;
  assign write_l = grant_l & req_l;

  // Source mux; an out-of-range select falls back to the memory source.
  always_comb begin
    pipe_data = in_src[int'(SRC_MEM)*N +: N];
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) begin
        pipe_data = in_src[k*N +: N];
      end
    end
  end

  // Register the granted write; address and data hold when no write issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= write_p | write_l;
      if (write_l) begin
        rf_waddr <= lu_rd;
        rf_wdata <= lu_data;
      end else if (write_p) begin
        rf_waddr <= in_rd;
        rf_wdata <= pipe_data;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  // Free-running activity counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pipe_wr  <= '0;
      stat_lu_wr    <= '0;
      stat_lu_stall <= '0;
    end else begin
      if (write_p)              stat_pipe_wr  <= stat_pipe_wr + 32'd1;
      if (write_l)              stat_lu_wr    <= stat_lu_wr + 32'd1;
      if (lu_valid & ~lu_ready) stat_lu_stall <= stat_lu_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Self-checking bench for wb_arbiter_stage. Three instances share stimulus:
// the default build, one with NSRC=3 and one with STARVE_LIMIT=0.
module tb_wb_arbiter_stage;

  localparam int N  = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, in_valid, in_reg_write, lu_valid;
  logic [RW-1:0]  in_rd, lu_rd;
  logic [1:0]     in_sel;
  logic [4*N-1:0] in_src;
  logic [3*N-1:0] in_src3;
  logic [N-1:0]   lu_data;

  logic          o_ir [3];
  logic          o_lr [3];
  logic          o_we [3];
  logic [RW-1:0] o_wa [3];
  logic [N-1:0]  o_wd [3];
`ifdef WB_ARB_STATS_EN
  logic [31:0]   o_sp [3];
  logic [31:0]   o_sl [3];
  logic [31:0]   o_ss [3];
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state, one slot per instance
  int            m_cnt [3];
  bit            m_we  [3];
  logic [RW-1:0] m_wa  [3];
  logic [N-1:0]  m_wd  [3];
  bit            e_ir  [3];
  bit            e_lr  [3];
  logic          seen_ir [3];
  logic          seen_lr [3];
`ifdef WB_ARB_STATS_EN
  int unsigned   m_sp [3];
  int unsigned   m_sl [3];
  int unsigned   m_ss [3];
`endif

  assign in_src3 = in_src[3*N-1:0];

  always #5 clk = ~clk;

  wb_arbiter_stage #(.N(N), .NSRC(4), .RW(RW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_ir[0]),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_sel(in_sel), .in_src(in_src),
    .lu_valid(lu_valid), .lu_ready(o_lr[0]), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(o_we[0]), .rf_waddr(o_wa[0]), .rf_wdata(o_wd[0])
`ifdef WB_ARB_STATS_EN
    , .stat_pipe_wr(o_sp[0]), .stat_lu_wr(o_sl[0]), .stat_lu_stall(o_ss[0])
`endif
  );

  wb_arbiter_stage #(.N(N), .NSRC(3), .RW(RW), .STARVE_LIMIT(4)) dut_nsrc3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_ir[1]),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_sel(in_sel), .in_src(in_src3),
    .lu_valid(lu_valid), .lu_ready(o_lr[1]), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(o_we[1]), .rf_waddr(o_wa[1]), .rf_wdata(o_wd[1])
`ifdef WB_ARB_STATS_EN
    , .stat_pipe_wr(o_sp[1]), .stat_lu_wr(o_sl[1]), .stat_lu_stall(o_ss[1])
`endif
  );

  wb_arbiter_stage #(.N(N), .NSRC(4), .RW(RW), .STARVE_LIMIT(0)) dut_lim0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_ir[2]),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_sel(in_sel), .in_src(in_src),
    .lu_valid(lu_valid), .lu_ready(o_lr[2]), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(o_we[2]), .rf_waddr(o_wa[2]), .rf_wdata(o_wd[2])
`ifdef WB_ARB_STATS_EN
    , .stat_pipe_wr(o_sp[2]), .stat_lu_wr(o_sl[2]), .stat_lu_stall(o_ss[2])
`endif
  );

  function automatic int lim_of(input int i);
    return (i == 2) ? 0 : 4;
  endfunction

  function automatic int nsrc_of(input int i);
    return (i == 1) ? 3 : 4;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_we[i]  = 1'b0;
      m_wa[i]  = '0;
      m_wd[i]  = '0;
`ifdef WB_ARB_STATS_EN
      m_sp[i] = 0;
      m_sl[i] = 0;
      m_ss[i] = 0;
`endif
    end
  endtask

  // Readiness from the arbitration rules: the long unit has priority once
  // it has lost STARVE_LIMIT cycles in a row; otherwise a live pipeline write wins.
  task automatic model_ready();
    bit prio;
    bit pipe_wants;
    pipe_wants = in_valid && in_reg_write && !flush;
    for (int i = 0; i < 3; i++) begin
      prio    = (m_cnt[i] == lim_of(i));
      e_ir[i] = !(lu_valid && prio);
      e_lr[i] = prio || !pipe_wants;
    end
  endtask

  // Advance the model one clock using the readiness computed for this cycle.
  task automatic model_clock();
    bit lu_win;
    bit pipe_win;
    bit pipe_wr;
    bit lu_wr;
    int sel;
    for (int i = 0; i < 3; i++) begin
      lu_win   = lu_valid && e_lr[i];
      pipe_win = in_valid && e_ir[i] && !lu_win;
      lu_wr    = lu_win && (lu_rd != 0);
      pipe_wr  = pipe_win && in_reg_write && !flush && (in_rd != 0);
      m_we[i]  = lu_wr || pipe_wr;
      if (lu_wr) begin
        m_wa[i] = lu_rd;
        m_wd[i] = lu_data;
      end else if (pipe_wr) begin
        sel = int'(in_sel);
        if (sel >= nsrc_of(i)) sel = 0;
        m_wa[i] = in_rd;
        m_wd[i] = in_src[sel*N +: N];
      end
`ifdef WB_ARB_STATS_EN
      if (pipe_wr) m_sp[i]++;
      if (lu_wr) m_sl[i]++;
      if (lu_valid && !e_lr[i]) m_ss[i]++;
`endif
      if (lu_valid && !e_lr[i]) m_cnt[i] = (m_cnt[i] + 1 > lim_of(i)) ? lim_of(i) : m_cnt[i] + 1;
      else m_cnt[i] = 0;
    end
  endtask

  // Drive one cycle, check readies before the edge and registered outputs after it.
  task automatic applyStimulus(input bit iv, input bit irw, input bit fl,
                               input logic [RW-1:0] rd, input logic [1:0] sel,
                               input bit lv, input logic [RW-1:0] lrd,
                               input logic [N-1:0] ld);
    in_valid = iv; in_reg_write = irw; flush = fl; in_rd = rd; in_sel = sel;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    #2;
    model_ready();
    for (int i = 0; i < 3; i++) begin
      seen_ir[i] = o_ir[i];
      seen_lr[i] = o_lr[i];
      checkOutput($sformatf("in_ready[%0d]", i), 32'(o_ir[i]), 32'(e_ir[i]));
      checkOutput($sformatf("lu_ready[%0d]", i), 32'(o_lr[i]), 32'(e_lr[i]));
    end
    @(posedge clk);
    model_clock();
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rf_we[%0d]", i), 32'(o_we[i]), 32'(m_we[i]));
      checkOutput($sformatf("rf_waddr[%0d]", i), 32'(o_wa[i]), 32'(m_wa[i]));
      checkOutput($sformatf("rf_wdata[%0d]", i), o_wd[i], m_wd[i]);
`ifdef WB_ARB_STATS_EN
      checkOutput($sformatf("stat_pipe_wr[%0d]", i), o_sp[i], m_sp[i]);
      checkOutput($sformatf("stat_lu_wr[%0d]", i), o_sl[i], m_sl[i]);
      checkOutput($sformatf("stat_lu_stall[%0d]", i), o_ss[i], m_ss[i]);
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_reg_write = 1'b0; flush = 1'b0; in_rd = '0; in_sel = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0; in_src = '0;
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_we[%0d]", i), 32'(o_we[i]), 32'd0);
      checkOutput($sformatf("reset_waddr[%0d]", i), 32'(o_wa[i]), 32'd0);
      checkOutput($sformatf("reset_wdata[%0d]", i), o_wd[i], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Plain pipeline write from the ALU source
    $display("[TB] pipeline write");
    in_src = {32'h0000_4444, 32'h0000_3333, 32'h0000_00AB, 32'h0000_1111};
    applyStimulus(1, 1, 0, 5'd7, 2'd1, 0, 5'd0, 32'h0);
    checkOutput("pipe_we", 32'(o_we[0]), 32'd1);
    checkOutput("pipe_waddr", 32'(o_wa[0]), 32'd7);
    checkOutput("pipe_wdata", o_wd[0], 32'h0000_00AB);

    // Asynchronous reset while a write is being presented
    $display("[TB] mid-cycle reset");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("async_reset_we[%0d]", i), 32'(o_we[i]), 32'd0);
      checkOutput($sformatf("async_reset_waddr[%0d]", i), 32'(o_wa[i]), 32'd0);
      checkOutput($sformatf("async_reset_wdata[%0d]", i), o_wd[i], 32'd0);
    end
    in_valid = 1'b0; lu_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Long unit held against a pipeline that writes every cycle
    $display("[TB] contention");
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 1, 0, 5'(10 + c), 2'(c), 1, 5'd3, 32'h0000_DEAD);
      if (c < 4) begin
        checkOutput($sformatf("contend_lu_ready_c%0d", c), 32'(seen_lr[0]), 32'd0);
      end else if (c == 4) begin
        checkOutput("contend_lu_ready_c4", 32'(seen_lr[0]), 32'd1);
        checkOutput("contend_in_ready_c4", 32'(seen_ir[0]), 32'd0);
        checkOutput("contend_waddr", 32'(o_wa[0]), 32'd3);
        checkOutput("contend_wdata", o_wd[0], 32'h0000_DEAD);
`ifdef WB_ARB_STATS_EN
        checkOutput("contend_stall_count", o_ss[0], 32'd4);
`endif
      end
    end

    // Flushed pipeline transaction alongside a long-unit result
    $display("[TB] flush with long unit");
    applyStimulus(1, 1, 1, 5'd12, 2'd0, 1, 5'd9, 32'h0000_0055);
    checkOutput("flush_in_ready", 32'(seen_ir[0]), 32'd1);
    checkOutput("flush_lu_ready", 32'(seen_lr[0]), 32'd1);
    checkOutput("flush_we", 32'(o_we[0]), 32'd1);
    checkOutput("flush_waddr", 32'(o_wa[0]), 32'd9);
    checkOutput("flush_wdata", o_wd[0], 32'h0000_0055);

    // Write to register 0 is accepted but not issued
    $display("[TB] register zero");
    applyStimulus(1, 1, 0, 5'd0, 2'd2, 0, 5'd0, 32'h0);
    checkOutput("rd0_in_ready", 32'(seen_ir[0]), 32'd1);
    checkOutput("rd0_we", 32'(o_we[0]), 32'd0);

    // Out-of-range select on the three-source instance
    $display("[TB] select out of range");
    in_src = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    applyStimulus(1, 1, 0, 5'd5, 2'd3, 0, 5'd0, 32'h0);
    checkOutput("nsrc3_sel3_wdata", o_wd[1], 32'hCAFE_0000);
    checkOutput("nsrc4_sel3_wdata", o_wd[0], 32'hCAFE_0003);

    // Zero starvation limit: the long unit always wins
    $display("[TB] permanent long-unit priority");
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, 1, 0, 5'd20, 2'd1, 1, 5'(4 + c), 32'(32'h100 + c));
      checkOutput($sformatf("lim0_lu_ready_c%0d", c), 32'(seen_lr[2]), 32'd1);
      checkOutput($sformatf("lim0_waddr_c%0d", c), 32'(o_wa[2]), 32'(4 + c));
    end

    // Randomised traffic with small register numbers to provoke collisions
    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++) begin
      in_src = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
                    5'($urandom_range(0, 3)), 32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
